// File: rtl/centisecond_stopwatch_pkg.sv
// centisecond_stopwatch_pkg: shared state, BCD types and count limits for the stopwatch.
package centisecond_stopwatch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;
  typedef logic [3:0] bcd_t;
  localparam int CS_MAX = 99;
  localparam int SEC_MAX = 59;
  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction
endpackage

// File: rtl/bcd_digit_pair_counter.sv
// bcd_digit_pair_counter: two-digit BCD counter that wraps to 00 after limit and flags the carry.
module bcd_digit_pair_counter
  import centisecond_stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  input  logic [7:0] limit,
  output bcd_t       tens,
  output bcd_t       ones,
  output logic       carry_out
);
  logic at_limit;
  assign at_limit = {tens, ones} == limit;
  assign carry_out = inc & at_limit;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens <= '0;
      ones <= '0;
    end else if (clr || carry_out) begin
      tens <= '0;
      ones <= '0;
    end else if (inc) begin
      ones <= (ones == 4'd9) ? 4'd0 : ones + 4'd1;
      tens <= (ones == 4'd9) ? tens + 4'd1 : tens;
    end
  end
endmodule

// File: rtl/centisecond_stopwatch.sv
// centisecond_stopwatch: MM:SS.cc BCD stopwatch advanced by synchronised cs_clk rising edges.
module centisecond_stopwatch
  import centisecond_stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_LIMIT = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_clk,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [7:0] cs_bcd,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic       running,
  output logic       lap_active,
  output logic       rollover
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic edge_q, tick, count_en, capture, cs_carry, sec_carry, min_carry;
  state_t state_q, state_d;
  bcd_t cs_t, cs_o, sec_t, sec_o, min_t, min_o;
  logic [23:0] live, frozen_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], cs_clk};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end
  assign tick = sync_q[SYNC_STAGES-1] & ~edge_q;
  assign running = (state_q == RUN) || (state_q == LAP);
  assign lap_active = state_q == LAP;
  assign count_en = tick & running & ~clear;
  // Capture reads the live value before this edge's increment lands.
  assign capture = lap & ~start_stop & ~clear & (state_q == RUN);
  always_comb begin
    state_d = state_q;
    state_d = clear ? IDLE
            : start_stop ? (running ? PAUSE : RUN)
            : (lap && state_q == RUN) ? LAP
            : (lap && state_q == LAP) ? RUN
            : state_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      frozen_q <= '0;
      rollover <= 1'b0;
    end else begin
      state_q <= state_d;
      frozen_q <= clear ? '0 : capture ? live : frozen_q;
      rollover <= min_carry;
    end
  end
  bcd_digit_pair_counter u_cs (
    .clk(clk), .rst_n(rst_n), .inc(count_en), .clr(clear), .limit(to_bcd(CS_MAX)),
    .tens(cs_t), .ones(cs_o), .carry_out(cs_carry)
  );
  bcd_digit_pair_counter u_sec (
    .clk(clk), .rst_n(rst_n), .inc(cs_carry), .clr(clear), .limit(to_bcd(SEC_MAX)),
    .tens(sec_t), .ones(sec_o), .carry_out(sec_carry)
  );
  bcd_digit_pair_counter u_min (
    .clk(clk), .rst_n(rst_n), .inc(sec_carry), .clr(clear), .limit(to_bcd(MIN_LIMIT)),
    .tens(min_t), .ones(min_o), .carry_out(min_carry)
  );
  assign live = {min_t, min_o, sec_t, sec_o, cs_t, cs_o};
  assign {min_bcd, sec_bcd, cs_bcd} = lap_active ? frozen_q : live;
endmodule

// File: doc/centisecond_stopwatch.md
Name: centisecond_stopwatch

Overview:
- Consumer end of the centisecond clock interface. Samples the free-running divided clock (cs_clk, toggles about every 10 ms half-period pair) in the system clock domain.
- Each cs_clk rising edge advances a BCD stopwatch (MM:SS.cc) under start/stop, lap and clear control.
- Drives the seven-segment display path and the alarm-compare logic.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on cs_clk (minimum 2).
- MIN_LIMIT, 59, highest minutes value before wrap to 00:00.00 (legal range 1..99).

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  asynchronous active-low reset.
- cs_clk  in  1  divided centisecond clock from the divider; asynchronous to logic sampling.
- start_stop  in  1  single-cycle pulse (already debounced); toggles run/pause.
- lap  in  1  single-cycle pulse; freezes or unfreezes the displayed value.
- clear  in  1  single-cycle pulse; zeroes time and returns to IDLE.
- cs_bcd  out  8  displayed centiseconds, two BCD digits (00..99).
- sec_bcd  out  8  displayed seconds, two BCD digits (00..59).
- min_bcd  out  8  displayed minutes, two BCD digits (00..MIN_LIMIT).
- running  out  1  high in RUN and LAP states.
- lap_active  out  1  high while the display is frozen.
- rollover  out  1  one-cycle pulse on wrap from MIN_LIMIT:59.99 to 00:00.00.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0, state IDLE.
  - Live and frozen time registers 00:00.00; synchroniser and edge flop cleared to 0.
  - Reset mid-run discards all time.
- Tick generation:
  - cs_clk passes through SYNC_STAGES flops, then one edge flop. tick = last sync stage high AND edge flop low.
  - With SYNC_STAGES=2, if cs_clk is first sampled high at clk edge N, the live time updates at edge N+2.
  - One tick per cs_clk rising edge. Falling edges are ignored.
- States:
  - IDLE: start_stop goes to RUN. lap is ignored.
  - RUN: ticks increment. start_stop goes to PAUSE. lap goes to LAP and captures the live value into the frozen register at the same edge.
  - LAP: ticks still increment live time; the display shows the frozen value. lap goes to RUN (display live again). start_stop goes to PAUSE and drops the freeze.
  - PAUSE: ticks ignored. start_stop goes to RUN. lap is ignored.
  - clear in any state: IDLE, live and frozen time set to 00:00.00, rollover 0.
- Counting (BCD, per digit):
  - cs units 9 wraps to 0 and carries to cs tens. cs 99 wraps to 00 and carries to seconds.
  - sec 59 wraps to 00 and carries to minutes.
  - min at MIN_LIMIT with a carry wraps to 00; rollover pulses for exactly one cycle, on the same edge.
  - No intermediate illegal BCD values are ever visible.
- Outputs: display outputs are a mux of registered live/frozen values, selected by lap_active. They change only on clk edges.
- Simultaneous events:
  - clear with anything: clear wins, and that cycle's tick is discarded.
  - start_stop with tick in RUN: the tick is counted, then the state goes to PAUSE.
  - start_stop with tick in PAUSE or IDLE: the tick is discarded, the state goes to RUN.
  - start_stop with lap: start_stop wins, lap is ignored.
  - lap with tick in RUN: the frozen value is the pre-increment live value.
- Glitch/metastability: cs_clk is never used as a clock inside this block.

Decomposition:
- Shared package:
  - state enum (IDLE, RUN, PAUSE, LAP).
  - BCD digit type (4 bits).
  - constant CS_MAX=99, SEC_MAX=59.
- One sub-module: bcd_digit_pair_counter.
  - Inputs: inc, clr, limit.
  - Outputs: two BCD digits and carry_out.
  - Instantiated three times and chained by carry.

Test Plan:
- Reset then start_stop, then 150 cs_clk periods -> display 00:01.50, running=1. First increment lands exactly 2 clk edges after cs_clk is first sampled high.
- RUN at 00:59.99, one cs_clk rise -> 01:00.00 in one clk edge, with no intermediate values.
- MIN_LIMIT=59, RUN at 59:59.99, one tick -> 00:00.00 and rollover high for exactly 1 cycle.
- RUN at 00:05.00, lap, then 300 ticks -> display holds 00:05.00 with lap_active=1. Second lap -> display 00:08.00.
- start_stop pulse coincident with tick in RUN at 00:00.07 -> 00:00.08 and PAUSE. 50 further ticks leave 00:00.08.
- clear coincident with tick and start_stop at 00:12.34 -> 00:00.00, IDLE, running=0.
- Drop rst_n asynchronously mid-RUN -> all outputs 0 immediately, without a clk edge.
